// File: rtl/mem_arbiter.sv
// N-channel arbiter that funnels cache-side rw_flag/addr/data requests onto a single
// memory request/ready port, one transfer at a time, with optional stall watchdog.
module mem_arbiter #(
    parameter int N_CH     = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [2*N_CH-1:0]              rw_flag_i,
    input  logic [ADDR_W*N_CH-1:0]         addr_i,
    input  logic [DATA_W*N_CH-1:0]         w_data_i,
    input  logic [(DATA_W/8)*N_CH-1:0]     w_mask_i,
    output logic [DATA_W*N_CH-1:0]         r_data_o,
    output logic [N_CH-1:0]                busy_o,
    output logic [N_CH-1:0]                done_o,
    output logic [N_CH-1:0]                err_o,
    output logic                           mem_req_o,
    output logic                           mem_we_o,
    output logic [ADDR_W-1:0]              mem_addr_o,
    output logic [DATA_W-1:0]              mem_w_data_o,
    output logic [DATA_W/8-1:0]            mem_w_mask_o,
    input  logic [DATA_W-1:0]              mem_r_data_i,
    input  logic                           mem_ready_i,
    output logic [1:0]                     dbg_state
);

    localparam int MASK_W = DATA_W / 8;
    localparam int PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  grant_q;
    logic [15:0]       wd;

    logic [N_CH-1:0]   pending;
    logic [PTR_W-1:0]  grant;
    logic              any_pending;
    logic              wd_hit;
    logic [N_CH-1:0]   grant_oh;

    assign dbg_state = state;
    assign grant_oh  = N_CH'(1) << grant_q;
    assign wd_hit    = (TIMEOUT > 0) && ((int'(wd) + 1) >= TIMEOUT);

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            pending[i] = |rw_flag_i[2*i +: 2];
        end
    end

    // Scan downward so the lowest index (or smallest offset from rr_ptr) wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        any_pending = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (ARB_MODE == 1) begin
                idx = k;
            end else begin
                idx = (int'(rr_ptr) + k) % N_CH;
            end
            if (pending[idx]) begin
                grant       = PTR_W'(idx);
                any_pending = 1'b1;
            end
        end
    end

    // Memory handshake: mem_req_o and all mem_* fields are held stable from REQ entry
    // until the first cycle mem_ready_i is sampled high; that edge completes the transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            grant_q      <= '0;
            wd           <= '0;
            r_data_o     <= '0;
            busy_o       <= '0;
            done_o       <= '0;
            err_o        <= '0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_w_data_o <= '0;
            mem_w_mask_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_pending) begin
                        grant_q      <= grant;
                        mem_req_o    <= 1'b1;
                        mem_we_o     <= rw_flag_i[2*grant + 1];
                        mem_addr_o   <= addr_i[grant*ADDR_W +: ADDR_W];
                        mem_w_data_o <= w_data_i[grant*DATA_W +: DATA_W];
                        mem_w_mask_o <= w_mask_i[grant*MASK_W +: MASK_W];
                        busy_o       <= '1;
                        wd           <= '0;
                        state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ready_i) begin
                        mem_req_o <= 1'b0;
                        done_o    <= grant_oh;
                        if (!mem_we_o) begin
                            r_data_o[grant_q*DATA_W +: DATA_W] <= mem_r_data_i;
                        end
                        state <= S_DONE;
                    end else if (wd_hit) begin
                        mem_req_o <= 1'b0;
                        done_o    <= grant_oh;
                        err_o     <= grant_oh;
                        state     <= S_DONE;
                    end else if (wd != 16'hFFFF) begin
                        wd <= wd + 16'd1;
                    end
                end
                S_DONE: begin
                    done_o <= '0;
                    err_o  <= '0;
                    busy_o <= '0;
                    if (ARB_MODE == 0) begin
                        if (int'(grant_q) == N_CH - 1) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= grant_q + PTR_W'(1);
                        end
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
